// File: rtl/m_ifetch_queue_pkg.sv
// rtl/m_ifetch_queue_pkg.sv - shared opcodes, NOP word and fetch-entry type for the fetch front-end
package m_ifetch_queue_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3f;

  localparam logic [31:0] NOP_WORD = 32'h00000020;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ifq_entry_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

endpackage

// File: rtl/m_ifq_fifo.sv
// rtl/m_ifq_fifo.sv - DEPTH-entry {pc, ir} queue with synchronous clear
module m_ifq_fifo
  import m_ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  ifq_entry_t             in_tdata,
  input  logic                   in_tvalid,
  output ifq_entry_t             out_tdata,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  ifq_entry_t     mem_q [DEPTH];
  ifq_entry_t     mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           push, pop;

  assign out_tvalid = (count_q != '0);
  assign out_tdata  = mem_q[rd_ptr_q];
  assign count      = count_q;

  always_comb begin
    push     = in_tvalid & ~clr;
    pop      = out_tvalid & out_tready & ~clr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_tdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset too so the head reads as a NOP at PC 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: 32'h0, ir: NOP_WORD};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/m_ifetch_queue.sv
// rtl/m_ifetch_queue.sv - instruction fetch front-end: fetch PC, credits, redirect, output queue
// IFQ_BYPASS_EN: forwards an arrival straight to ID when the queue is empty
module m_ifetch_queue
  import m_ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic          w_clk,
  input  logic          w_rst,
  output logic [AW-1:0] r_iaddr,
  input  logic [31:0]   w_idata,
  input  logic          w_redirect,
  input  logic [31:0]   w_tpc,
  input  logic          w_halt,
  input  logic          w_ready,
  output logic          r_valid,
  output logic [31:0]   r_ir,
  output logic [31:0]   r_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   ppc_q, ppc_d;
  logic          pend_q, pend_d;
  logic [31:0]   issue_pc;
  logic          issue;
  logic [CW:0]   credit_used;
  logic          arrival;
  logic          push;
  logic [CW-1:0] fifo_count;
  logic          head_valid;
  ifq_entry_t    head;
  ifq_entry_t    arr_entry;
`ifdef IFQ_BYPASS_EN
  logic          bypass;
`endif

  // Low target bits carry no meaning for word-aligned fetch.
  logic unused_tpc_lsb;
  assign unused_tpc_lsb = ^w_tpc[1:0];

  always_comb begin
    issue_pc    = w_redirect ? {w_tpc[31:2], 2'b00} : fpc_q;
    r_iaddr     = issue_pc[AW+1:2];
    credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, pend_q};
    issue       = w_redirect | (~w_halt & (credit_used < DEPTH_W));
    pend_d      = issue;
    fpc_d       = issue ? issue_pc + 32'd4 : fpc_q;
    ppc_d       = issue ? issue_pc : ppc_q;
    arrival     = pend_q & ~w_redirect;
    arr_entry   = '{pc: ppc_q, ir: w_idata};
`ifdef IFQ_BYPASS_EN
    bypass      = arrival & ~head_valid;
    r_valid     = head_valid | bypass;
    r_ir        = bypass ? w_idata : head.ir;
    r_pc        = bypass ? ppc_q : head.pc;
    push        = arrival & ~(bypass & w_ready);
`else
    r_valid     = head_valid;
    r_ir        = head.ir;
    r_pc        = head.pc;
    push        = arrival;
`endif
  end

  // Redirect clears the queue and blocks any pop in the same cycle.
  m_ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (w_clk),
    .rst        (w_rst),
    .clr        (w_redirect),
    .in_tdata   (arr_entry),
    .in_tvalid  (push),
    .out_tdata  (head),
    .out_tvalid (head_valid),
    .out_tready (w_ready),
    .count      (fifo_count)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      fpc_q  <= 32'h0;
      ppc_q  <= 32'h0;
      pend_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      ppc_q  <= ppc_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// tb/tb_m_ifetch_queue.sv - directed and random checks of m_ifetch_queue against a queue model
module tb_m_ifetch_queue;
  import m_ifetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 12;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic [AW-1:0] r_iaddr;
  logic [31:0]   w_idata;
  logic          w_redirect;
  logic [31:0]   w_tpc;
  logic          w_halt;
  logic          w_ready;
  logic          r_valid;
  logic [31:0]   r_ir;
  logic [31:0]   r_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_fpc;
  logic [31:0] m_ppc;
  bit          m_pend;
  logic [63:0] m_q[$];

  m_ifetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .r_iaddr    (r_iaddr),
    .w_idata    (w_idata),
    .w_redirect (w_redirect),
    .w_tpc      (w_tpc),
    .w_halt     (w_halt),
    .w_ready    (w_ready),
    .r_valid    (r_valid),
    .r_ir       (r_ir),
    .r_pc       (r_pc)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] mk_instr(input logic [AW-1:0] a);
    return {OP_ADDI, 5'd1, 5'd2, 4'h0, a};
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge w_clk) w_idata <= mk_instr(r_iaddr);

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    bit          exp_v;
    logic [63:0] hd;
    logic [31:0] exp_addr;
    @(negedge w_clk);
    exp_addr = w_redirect ? w_tpc : m_fpc;
    exp_v = (m_q.size() != 0) || (BYP && m_pend && !w_redirect);
    hd = (m_q.size() != 0) ? m_q[0] : {m_ppc, mk_instr(m_ppc[AW+1:2])};
    check("iaddr", {20'b0, r_iaddr}, {20'b0, exp_addr[AW+1:2]});
    check("valid", {31'b0, r_valid}, {31'b0, exp_v});
    if (exp_v) begin
      check("pc", r_pc, hd[63:32]);
      check("ir", r_ir, hd[31:0]);
    end
  endtask

  task automatic advance();
    bit          iss, arr, pop, take;
    logic [31:0] ipc;
    @(posedge w_clk);
    if (w_rst) begin
      m_q.delete();
      m_fpc  = 32'h0;
      m_ppc  = 32'h0;
      m_pend = 1'b0;
    end else begin
      ipc = w_redirect ? {w_tpc[31:2], 2'b00} : m_fpc;
      iss = w_redirect || (!w_halt && (m_q.size() + int'(m_pend) < DEPTH));
      if (w_redirect) begin
        m_q.delete();
      end else begin
        arr  = m_pend;
        pop  = (m_q.size() != 0) && w_ready;
        take = BYP && arr && (m_q.size() == 0) && w_ready;
        if (pop) void'(m_q.pop_front());
        if (arr && !take) m_q.push_back({m_ppc, mk_instr(m_ppc[AW+1:2])});
      end
      m_pend = iss;
      if (iss) begin
        m_ppc = ipc;
        m_fpc = ipc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    w_rst      = 1'b1;
    w_redirect = 1'b0;
    w_halt     = 1'b0;
    w_ready    = rdy;
    w_tpc      = 32'h0;
    advance();
    advance();
    w_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] last_pc;
    logic [31:0] drain [5];
    drain[0] = 32'h0; drain[1] = 32'h4; drain[2] = 32'h8; drain[3] = 32'hC; drain[4] = 32'h10;
    w_rst = 1'b1; w_redirect = 1'b0; w_halt = 1'b0; w_ready = 1'b1; w_tpc = 32'h0;

    // Reset values and streaming with ready held high
    do_reset(1'b1);
    for (int c = 0; c < LAT + 4; c++) begin
      sample();
      if (c == 0) begin
        check("rst_ir", r_ir, NOP_WORD);
        check("rst_pc", r_pc, 32'h0);
        check("rst_iaddr", {20'b0, r_iaddr}, 32'h0);
      end
      if (c < LAT) check("t1_idle", {31'b0, r_valid}, 32'd0);
      else begin
        check("t1_valid", {31'b0, r_valid}, 32'd1);
        check("t1_pc", r_pc, 32'(4 * (c - LAT)));
      end
      advance();
    end

    // Stall ID: queue fills to DEPTH and fetch stops
    do_reset(1'b0);
    repeat (10) begin sample(); advance(); end
    w_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (c == 0) check("t2_iaddr", {20'b0, r_iaddr}, 32'h4);
      check("t2_valid", {31'b0, r_valid}, 32'd1);
      check("t2_pc", r_pc, drain[c]);
      advance();
    end

    // Redirect with 3 queued and one in flight
    do_reset(1'b0);
    repeat (4) begin sample(); advance(); end
    w_redirect = 1'b1; w_tpc = 32'h40;
    sample(); advance();
    w_redirect = 1'b0; w_ready = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      sample();
      if (c < LAT) check("t3_nostale", {31'b0, r_valid}, 32'd0);
      else begin
        check("t3_valid", {31'b0, r_valid}, 32'd1);
        check("t3_pc", r_pc, 32'h40);
      end
      advance();
    end
    sample(); check("t3_next", r_pc, 32'h44); advance();

    // Redirect together with ready while full
    do_reset(1'b0);
    repeat (6) begin sample(); advance(); end
    w_redirect = 1'b1; w_ready = 1'b1; w_tpc = 32'h83;
    sample(); advance();
    w_redirect = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      sample();
      if (c < LAT) check("t4_flushed", {31'b0, r_valid}, 32'd0);
      else check("t4_pc", r_pc, 32'h80);
      advance();
    end

    // Halt after pc 0x14 is issued
    do_reset(1'b1);
    for (int c = 0; c < 20 && r_iaddr != 12'd5; c++) begin sample(); advance(); end
    sample(); advance();
    w_halt = 1'b1;
    check("t5_reach", {20'b0, r_iaddr}, 32'h6);
    last_pc = 32'hFFFF_FFFF;
    repeat (6) begin
      sample();
      if (r_valid) last_pc = r_pc;
      advance();
    end
    sample();
    check("t5_drained", {31'b0, r_valid}, 32'd0);
    check("t5_iaddr", {20'b0, r_iaddr}, 32'h6);
    check("t5_last", last_pc, 32'h14);
    advance();
    w_halt = 1'b0;
    for (int c = 0; c <= LAT; c++) begin
      sample();
      if (c == LAT) check("t5_resume", r_pc, 32'h18);
      advance();
    end

    // Reset mid-stream with 2 entries queued
    do_reset(1'b0);
    repeat (3) begin sample(); advance(); end
    w_rst = 1'b1;
    sample();
    check("t6_queued", {31'b0, r_valid}, 32'd1);
    advance();
    w_rst = 1'b0;
    for (int c = 0; c <= LAT; c++) begin
      sample();
      if (c == 0) begin
        check("t6_valid", {31'b0, r_valid}, 32'd0);
        check("t6_ir", r_ir, NOP_WORD);
        check("t6_iaddr", {20'b0, r_iaddr}, 32'h0);
      end
      if (c == LAT) check("t6_pc", r_pc, 32'h0);
      w_ready = 1'b1;
      advance();
    end

    // Random traffic against the model
    do_reset(1'b1);
    for (int i = 0; i < 500; i++) begin
      w_ready    = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) w_halt = ~w_halt;
      w_redirect = ($urandom_range(11) == 0);
      w_tpc      = ($urandom_range(5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      w_rst      = ($urandom_range(99) == 0);
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
